// File: rtl/pc_sequencer.sv
// -----------------------------------------------------------------------------
// pc_sequencer
//   Registered program-counter sequencer for the 16-bit core. Selects the next
//   PC from jump, branch, return, sequential and loop-end sources, and keeps a
//   circular return-address stack (RAS) plus a single-level hardware loop
//   counter.
//
// Ports
//   clk, reset        rising-edge clock, asynchronous active-high reset
//   pc_en             1 = advance this cycle, 0 = stall (all state holds)
//   pc_increment      1 = honour pc_sel, 0 = force sequential, no side effects
//   pc_sel            000 jump, 001 branch, 010 ret, 011 seq, 100 loop-end
//   jump_off, call    jump target low bits; call pushes pc+1 on a jump
//   br_imm, br_taken  signed branch offset and branch condition
//   loop_load         load loop_count and loop start address (pc+1)
//   loop_count        iteration count for loop_load
//   pc                current PC
//   loop_active       loop counter != 0
//   ras_empty/full    RAS occupancy flags
//   ras_ovf/unf       sticky push-while-full / pop-while-empty flags
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module pc_sequencer #(
    parameter int unsigned    PC_W      = 16,
    parameter int unsigned    JOFF_W    = 9,
    parameter int unsigned    BIMM_W    = 6,
    parameter int unsigned    RAS_DEPTH = 8,
    parameter int unsigned    LOOP_W    = 16,
    parameter logic [PC_W-1:0] RESET_PC = '0
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              pc_en,
    input  logic              pc_increment,
    input  logic [2:0]        pc_sel,
    input  logic [JOFF_W-1:0] jump_off,
    input  logic              call,
    input  logic [BIMM_W-1:0] br_imm,
    input  logic              br_taken,
    input  logic              loop_load,
    input  logic [LOOP_W-1:0] loop_count,
    output logic [PC_W-1:0]   pc,
    output logic              loop_active,
    output logic              ras_empty,
    output logic              ras_full,
    output logic              ras_ovf,
    output logic              ras_unf
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 2) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;

    localparam logic [2:0] SEL_JUMP = 3'b000;
    localparam logic [2:0] SEL_BR   = 3'b001;
    localparam logic [2:0] SEL_RET  = 3'b010;
    localparam logic [2:0] SEL_LOOP = 3'b100;

    // Architectural state
    logic [PC_W-1:0]   pc_q,        pc_d;
    logic [PTR_W-1:0]  ras_ptr_q,   ras_ptr_d;   // next write slot
    logic [CNT_W-1:0]  ras_cnt_q,   ras_cnt_d;
    logic [LOOP_W-1:0] loop_cnt_q,  loop_cnt_d;
    logic [PC_W-1:0]   loop_addr_q, loop_addr_d;
    logic              ras_ovf_q,   ras_ovf_d;
    logic              ras_unf_q,   ras_unf_d;
    logic              ras_empty_q, ras_empty_d;
    logic              ras_full_q,  ras_full_d;
    logic              loop_act_q,  loop_act_d;

    logic [PC_W-1:0]   ras_mem [RAS_DEPTH];

    logic [PC_W-1:0]   seq_pc_c;
    logic [PC_W-1:0]   jump_pc_c;
    logic [PC_W-1:0]   br_pc_c;
    logic [PC_W-1:0]   ras_top_c;
    logic              ras_push_c;

    // Candidate next-PC values; all arithmetic wraps modulo 2^PC_W
    always_comb begin
        seq_pc_c  = pc_q + PC_W'(1);
        jump_pc_c = {pc_q[PC_W-1:JOFF_W], jump_off};
        br_pc_c   = pc_q + {{(PC_W-BIMM_W){br_imm[BIMM_W-1]}}, br_imm};
        ras_top_c = ras_mem[ras_ptr_q - PTR_W'(1)];
    end

    // Next-state selection
    always_comb begin
        pc_d        = seq_pc_c;
        ras_ptr_d   = ras_ptr_q;
        ras_cnt_d   = ras_cnt_q;
        loop_cnt_d  = loop_cnt_q;
        loop_addr_d = loop_addr_q;
        ras_ovf_d   = ras_ovf_q;
        ras_unf_d   = ras_unf_q;
        ras_push_c  = 1'b0;

        if (pc_increment) begin
            case (pc_sel)
                SEL_JUMP: begin
                    pc_d = jump_pc_c;
                    if (call) begin
                        // Full stack overwrites the oldest slot; count saturates
                        ras_push_c = 1'b1;
                        ras_ptr_d  = ras_ptr_q + PTR_W'(1);
                        if (ras_cnt_q == CNT_W'(RAS_DEPTH)) begin
                            ras_ovf_d = 1'b1;
                        end else begin
                            ras_cnt_d = ras_cnt_q + CNT_W'(1);
                        end
                    end
                end
                SEL_BR: begin
                    if (br_taken) begin
                        pc_d = br_pc_c;
                    end
                end
                SEL_RET: begin
                    if (ras_cnt_q != '0) begin
                        pc_d      = ras_top_c;
                        ras_ptr_d = ras_ptr_q - PTR_W'(1);
                        ras_cnt_d = ras_cnt_q - CNT_W'(1);
                    end else begin
                        ras_unf_d = 1'b1;
                    end
                end
                SEL_LOOP: begin
                    // A same-cycle loop_load wins: pc falls through to seq
                    if (!loop_load) begin
                        if (loop_cnt_q > LOOP_W'(1)) begin
                            loop_cnt_d = loop_cnt_q - LOOP_W'(1);
                            pc_d       = loop_addr_q;
                        end else begin
                            loop_cnt_d = '0;
                        end
                    end
                end
                default: ;
            endcase
        end

        if (loop_load) begin
            loop_cnt_d  = loop_count;
            loop_addr_d = seq_pc_c;
        end

        ras_empty_d = (ras_cnt_d == '0);
        ras_full_d  = (ras_cnt_d == CNT_W'(RAS_DEPTH));
        loop_act_d  = (loop_cnt_d != '0);
    end

    // State registers
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            pc_q        <= RESET_PC;
            ras_ptr_q   <= '0;
            ras_cnt_q   <= '0;
            loop_cnt_q  <= '0;
            loop_addr_q <= '0;
            ras_ovf_q   <= 1'b0;
            ras_unf_q   <= 1'b0;
            ras_empty_q <= 1'b1;
            ras_full_q  <= 1'b0;
            loop_act_q  <= 1'b0;
        end else if (pc_en) begin
            pc_q        <= pc_d;
            ras_ptr_q   <= ras_ptr_d;
            ras_cnt_q   <= ras_cnt_d;
            loop_cnt_q  <= loop_cnt_d;
            loop_addr_q <= loop_addr_d;
            ras_ovf_q   <= ras_ovf_d;
            ras_unf_q   <= ras_unf_d;
            ras_empty_q <= ras_empty_d;
            ras_full_q  <= ras_full_d;
            loop_act_q  <= loop_act_d;
        end
    end

    // RAS storage; contents are only meaningful below ras_cnt_q
    always_ff @(posedge clk) begin
        if (pc_en && ras_push_c) begin
            ras_mem[ras_ptr_q] <= seq_pc_c;
        end
    end

    assign pc          = pc_q;
    assign loop_active = loop_act_q;
    assign ras_empty   = ras_empty_q;
    assign ras_full    = ras_full_q;
    assign ras_ovf     = ras_ovf_q;
    assign ras_unf     = ras_unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
`timescale 1ns/1ps

module tb_pc_sequencer;

    localparam logic [2:0] S_JMP = 3'b000;
    localparam logic [2:0] S_BR  = 3'b001;
    localparam logic [2:0] S_RET = 3'b010;
    localparam logic [2:0] S_SEQ = 3'b011;
    localparam logic [2:0] S_LP  = 3'b100;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        pc_en = 1'b1;
    logic        pc_increment = 1'b1;
    logic [2:0]  pc_sel = S_SEQ;
    logic [8:0]  jump_off = '0;
    logic        call = 1'b0;
    logic [5:0]  br_imm = '0;
    logic        br_taken = 1'b0;
    logic        loop_load = 1'b0;
    logic [15:0] loop_count = '0;
    logic [15:0] pc;
    logic        loop_active, ras_empty, ras_full, ras_ovf, ras_unf;

    logic [15:0] exp_q [$];
    logic [15:0] e;
    int          n_checks = 0;
    int          n_fail = 0;

    pc_sequencer dut (
        .clk(clk), .reset(reset), .pc_en(pc_en), .pc_increment(pc_increment),
        .pc_sel(pc_sel), .jump_off(jump_off), .call(call), .br_imm(br_imm),
        .br_taken(br_taken), .loop_load(loop_load), .loop_count(loop_count),
        .pc(pc), .loop_active(loop_active), .ras_empty(ras_empty),
        .ras_full(ras_full), .ras_ovf(ras_ovf), .ras_unf(ras_unf)
    );

    always #5 clk = ~clk;

    // Drive one cycle of stimulus and queue the PC it must produce
    task automatic drive_op(input logic [2:0] sel, input logic [8:0] joff,
                            input logic cl, input logic [5:0] imm, input logic tk,
                            input logic ll, input logic [15:0] lc,
                            input logic [15:0] exp_pc);
        pc_sel = sel; jump_off = joff; call = cl; br_imm = imm;
        br_taken = tk; loop_load = ll; loop_count = lc;
        exp_q.push_back(exp_pc);
        @(posedge clk); #1;
        call = 1'b0; loop_load = 1'b0; br_taken = 1'b0; pc_sel = S_SEQ;
    endtask

    task automatic do_reset();
        pc_en = 1'b1; pc_increment = 1'b1; pc_sel = S_SEQ;
        reset = 1'b1; #3; reset = 1'b0;
        @(posedge clk); #1;
        // the single edge above advanced pc by one from reset; return to block 0 base
        pc_sel = S_JMP; jump_off = 9'h000; @(posedge clk); #1;
        pc_sel = S_SEQ;
    endtask

    // Walk from block 0 to target using jumps to block end plus one seq step
    task automatic goto_pc(input logic [15:0] target);
        for (int b = 0; b < int'(target[15:9]); b++) begin
            pc_sel = S_JMP; jump_off = 9'h1FF; @(posedge clk); #1;
            pc_sel = S_SEQ; @(posedge clk); #1;
        end
        pc_sel = S_JMP; jump_off = target[8:0]; @(posedge clk); #1;
        pc_sel = S_SEQ;
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (pc !== 16'h0000 || ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
            n_fail++; $display("FAIL reset_state pc=%h empty=%b unf=%b exp 0000/1/0", pc, ras_empty, ras_unf); end
        drive_op(S_RET, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0001);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || ras_unf !== 1'b1) begin
            n_fail++; $display("FAIL ret_empty pc=%h unf=%b exp %h/1", pc, ras_unf, e); end
        drive_op(S_SEQ, 9'h0, 1'b0, 6'h0, 1'b0, 1'b1, 16'd5, 16'h0002);
        e = exp_q.pop_front();
        drive_op(S_JMP, 9'h0, 1'b1, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0000);
        e = exp_q.pop_front();
        goto_pc(16'h1234);
        n_checks++; if (pc !== 16'h1234 || ras_empty !== 1'b0 || loop_active !== 1'b1) begin
            n_fail++; $display("FAIL pre_reset pc=%h empty=%b lact=%b exp 1234/0/1", pc, ras_empty, loop_active); end
        // async reset mid-cycle, no clock edge in between
        #2; reset = 1'b1; #1;
        n_checks++; if (pc !== 16'h0000 || ras_unf !== 1'b0 || ras_ovf !== 1'b0 ||
                         ras_empty !== 1'b1 || ras_full !== 1'b0 || loop_active !== 1'b0) begin
            n_fail++; $display("FAIL async_reset pc=%h unf=%b ovf=%b empty=%b full=%b lact=%b exp 0000/0/0/1/0/0",
                               pc, ras_unf, ras_ovf, ras_empty, ras_full, loop_active); end
        #2; reset = 1'b0;
        @(posedge clk); #1;
    endtask

    task automatic test_jump_call_ret();
        do_reset();
        goto_pc(16'h0A05);
        drive_op(S_JMP, 9'h1F0, 1'b1, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0BF0);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || ras_empty !== 1'b0) begin
            n_fail++; $display("FAIL jump_call pc=%h empty=%b exp %h/0", pc, ras_empty, e); end
        // pc_increment=0 forces seq and must not pop
        pc_increment = 1'b0;
        drive_op(S_RET, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0BF1);
        pc_increment = 1'b1;
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || ras_empty !== 1'b0) begin
            n_fail++; $display("FAIL noinc_ret pc=%h empty=%b exp %h/0", pc, ras_empty, e); end
        drive_op(S_RET, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0A06);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || ras_empty !== 1'b1 || ras_unf !== 1'b0) begin
            n_fail++; $display("FAIL ret pc=%h empty=%b unf=%b exp %h/1/0", pc, ras_empty, ras_unf, e); end
    endtask

    task automatic test_branch();
        do_reset();
        goto_pc(16'h0010);
        drive_op(S_BR, 9'h0, 1'b0, 6'h3E, 1'b1, 1'b0, 16'd0, 16'h000E);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e) begin n_fail++; $display("FAIL br_taken pc=%h exp %h", pc, e); end
        goto_pc(16'h0010);
        drive_op(S_BR, 9'h0, 1'b0, 6'h3E, 1'b0, 1'b0, 16'd0, 16'h0011);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e) begin n_fail++; $display("FAIL br_not_taken pc=%h exp %h", pc, e); end
        drive_op(S_BR, 9'h0, 1'b0, 6'h1F, 1'b1, 1'b0, 16'd0, 16'h0030);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e) begin n_fail++; $display("FAIL br_fwd pc=%h exp %h", pc, e); end
        pc_increment = 1'b0;
        drive_op(S_BR, 9'h0, 1'b0, 6'h1F, 1'b1, 1'b0, 16'd0, 16'h0031);
        pc_increment = 1'b1;
        e = exp_q.pop_front();
        n_checks++; if (pc !== e) begin n_fail++; $display("FAIL noinc_br pc=%h exp %h", pc, e); end
    endtask

    task automatic test_wrap_stall();
        do_reset();
        drive_op(S_BR, 9'h0, 1'b0, 6'h3F, 1'b1, 1'b0, 16'd0, 16'hFFFF);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e) begin n_fail++; $display("FAIL br_wrap pc=%h exp %h", pc, e); end
        drive_op(S_SEQ, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0000);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e) begin n_fail++; $display("FAIL seq_wrap pc=%h exp %h", pc, e); end
        pc_en = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive_op(S_JMP, 9'h155, 1'b1, 6'h0, 1'b0, 1'b1, 16'd7, 16'h0000);
            e = exp_q.pop_front();
            n_checks++; if (pc !== e || ras_empty !== 1'b1 || loop_active !== 1'b0) begin
                n_fail++; $display("FAIL stall%0d pc=%h empty=%b lact=%b exp %h/1/0", i, pc, ras_empty, loop_active, e); end
        end
        pc_en = 1'b1;
        drive_op(S_SEQ, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0001);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e) begin n_fail++; $display("FAIL post_stall pc=%h exp %h", pc, e); end
    endtask

    task automatic test_ras_overflow();
        logic [15:0] stk [$];
        logic [15:0] mpc;
        logic [15:0] tgt;
        do_reset();
        mpc = 16'h0000;
        for (int i = 0; i < 9; i++) begin
            tgt = 16'(32 * (i + 1));
            stk.push_back(mpc + 16'd1);
            if (stk.size() > 8) void'(stk.pop_front());
            drive_op(S_JMP, tgt[8:0], 1'b1, 6'h0, 1'b0, 1'b0, 16'd0, tgt);
            mpc = tgt;
            e = exp_q.pop_front();
            n_checks++; if (pc !== e || ras_full !== (i >= 7) || ras_ovf !== (i == 8)) begin
                n_fail++; $display("FAIL call%0d pc=%h full=%b ovf=%b exp %h/%b/%b", i, pc, ras_full, ras_ovf, e, (i >= 7), (i == 8)); end
        end
        for (int i = 0; i < 9; i++) begin
            tgt = (stk.size() != 0) ? stk.pop_back() : mpc + 16'd1;
            drive_op(S_RET, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, tgt);
            mpc = tgt;
            e = exp_q.pop_front();
            n_checks++; if (pc !== e || ras_unf !== (i == 8) || ras_empty !== (i >= 7) || ras_ovf !== 1'b1) begin
                n_fail++; $display("FAIL ret%0d pc=%h unf=%b empty=%b ovf=%b exp %h/%b/%b/1", i, pc, ras_unf, ras_empty, ras_ovf, e, (i == 8), (i >= 7)); end
        end
    endtask

    task automatic test_loop();
        int body = 0;
        do_reset();
        goto_pc(16'h0020);
        drive_op(S_SEQ, 9'h0, 1'b0, 6'h0, 1'b0, 1'b1, 16'd3, 16'h0021);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || loop_active !== 1'b1) begin
            n_fail++; $display("FAIL loop_load pc=%h lact=%b exp %h/1", pc, loop_active, e); end
        for (int it = 0; it < 3; it++) begin
            if (pc == 16'h0021) body++;
            drive_op(S_SEQ, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0022);
            e = exp_q.pop_front();
            n_checks++; if (pc !== e) begin n_fail++; $display("FAIL body%0d pc=%h exp %h", it, pc, e); end
            drive_op(S_LP, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, (it < 2) ? 16'h0021 : 16'h0023);
            e = exp_q.pop_front();
            n_checks++; if (pc !== e) begin n_fail++; $display("FAIL loop_end%0d pc=%h exp %h", it, pc, e); end
        end
        n_checks++; if (body !== 3 || loop_active !== 1'b0) begin
            n_fail++; $display("FAIL loop_done body=%0d lact=%b exp 3/0", body, loop_active); end
        // loop_load beats loop-end in the same cycle
        drive_op(S_LP, 9'h0, 1'b0, 6'h0, 1'b0, 1'b1, 16'd2, 16'h0024);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || loop_active !== 1'b1) begin
            n_fail++; $display("FAIL load_vs_end pc=%h lact=%b exp %h/1", pc, loop_active, e); end
        pc_increment = 1'b0;
        drive_op(S_LP, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0025);
        pc_increment = 1'b1;
        e = exp_q.pop_front();
        drive_op(S_LP, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0024);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || loop_active !== 1'b1) begin
            n_fail++; $display("FAIL noinc_kept_cnt pc=%h lact=%b exp %h/1", pc, loop_active, e); end
        drive_op(S_LP, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0025);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || loop_active !== 1'b0) begin
            n_fail++; $display("FAIL loop2_exit pc=%h lact=%b exp %h/0", pc, loop_active, e); end
        drive_op(S_SEQ, 9'h0, 1'b0, 6'h0, 1'b0, 1'b1, 16'd0, 16'h0026);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e || loop_active !== 1'b0) begin
            n_fail++; $display("FAIL load_zero pc=%h lact=%b exp %h/0", pc, loop_active, e); end
        drive_op(S_LP, 9'h0, 1'b0, 6'h0, 1'b0, 1'b0, 16'd0, 16'h0027);
        e = exp_q.pop_front();
        n_checks++; if (pc !== e) begin n_fail++; $display("FAIL zero_end pc=%h exp %h", pc, e); end
    endtask

    initial begin
        @(posedge clk); #1;
        test_reset();
        test_jump_call_ret();
        test_branch();
        test_wrap_stall();
        test_ras_overflow();
        test_loop();
        n_checks++; if (exp_q.size() != 0) begin
            n_fail++; $display("FAIL scoreboard_drain left=%0d exp 0", exp_q.size()); end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
